// File: rtl/pcie_dn_dfk_pkg.sv
// Shared types and helpers for the downstream descriptor-fetch scheduler.
package pcie_dn_dfk_pkg;

    // Request-issue FSM: wait for a winner, then hold the read until accepted.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } dfk_state_e;

    localparam int          TAG_W         = 8;
    localparam int          DCNT_W        = 12;
    localparam int          MAP_MAX       = 16;
    localparam logic [11:0] DESC_DCNT_DEF = 12'd8;

    // Number of set bits in a busy map of up to MAP_MAX tags.
    function automatic logic [4:0] popcount16(input logic [MAP_MAX-1:0] v);
        logic [4:0] c;
        c = 5'd0;
        for (int i = 0; i < MAP_MAX; i++) begin
            c = c + {4'd0, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/pcie_dn_dfk_sched_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after the
// pointer wins. The pointer register lives in the parent.
module pcie_rr_arb #(
    parameter int NCH = 4,
    parameter int PW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req_i,
    input  logic [PW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [PW-1:0]  idx_o,
    output logic           vld_o
);

    // Scan the channels starting at the pointer and take the first requester.
    always_comb begin : arb_scan
        logic [PW-1:0] cand;
        cand  = '0;
        gnt_o = '0;
        idx_o = '0;
        vld_o = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            cand = PW'((int'(ptr_i) + k) % NCH);
            if (!vld_o && req_i[cand]) begin
                vld_o       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end else begin
                vld_o = vld_o;
            end
        end
    end

endmodule

// File: rtl/pcie_dn_dfk_sched.sv
// Descriptor-fetch scheduler: arbitrates channel fetch requests, issues one
// memory read per winner with a free tag, and frees tags on completion EOP.
module pcie_dn_dfk_sched
    import pcie_dn_dfk_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          MAX_OUTS  = 4,
    parameter logic [7:0]  TAG_BASE  = 8'h00,
    parameter logic [11:0] DESC_DCNT = DESC_DCNT_DEF,
    parameter int          TMO_CYC   = 65535
) (
    input  logic              PCIE_CLK,
    input  logic              PCIE_RST_N,
    input  logic              ENABLE,
    input  logic [NCH-1:0]    CH_REQ,
    input  logic [NCH*64-1:0] CH_ADDR,
    output logic [NCH-1:0]    CH_GNT,
    output logic              DFK_RQ_VLD,
    input  logic              DFK_RQ_RDY,
    output logic [63:0]       DFK_RQ_ADDR,
    output logic [TAG_W-1:0]  DFK_RQ_TAG,
    output logic [DCNT_W-1:0] DFK_RQ_DCNT,
    input  logic              DFK_CP_EOP,
    input  logic              DFK_CP_DVLD,
    input  logic [TAG_W-1:0]  DFK_CP_TAG,
    output logic [4:0]        OUTS_CNT,
    output logic              BUSY,
    output logic              UNEXP_TAG,
    output logic              TMO_ERR
);

    localparam int PW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TIW = (MAX_OUTS > 1) ? $clog2(MAX_OUTS) : 1;

    dfk_state_e          state_q, state_d;
    logic [MAX_OUTS-1:0] busy_q, busy_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       win_idx_q, win_idx_d;
    logic [NCH-1:0]      win_oh_q, win_oh_d;
    logic [63:0]         addr_q, addr_d;
    logic [TIW-1:0]      tag_q, tag_d;
    logic [31:0]         wdog_q, wdog_d;
    logic [4:0]          cnt_q, cnt_d;
    logic                unexp_q, unexp_d;
    logic                tmo_q, tmo_d;

    logic [NCH-1:0]      arb_gnt_s;
    logic [PW-1:0]       arb_idx_s;
    logic                arb_vld_s;
    logic [63:0]         addr_sel_s;
    logic                free_vld_s;
    logic [TIW-1:0]      free_idx_s;
    logic                accept_s;
    logic                cp_eop_s;
    logic [8:0]          cp_off_s;
    logic [TIW-1:0]      cp_idx_s;
    logic                cp_hit_s;
    logic [MAX_OUTS-1:0] free_mask_s;
    logic [MAX_OUTS-1:0] alloc_mask_s;
    logic [MAP_MAX-1:0]  busy_ext_s;

    pcie_rr_arb #(
        .NCH (NCH),
        .PW  (PW)
    ) u_arb (
        .req_i (CH_REQ),
        .ptr_i (ptr_q),
        .gnt_o (arb_gnt_s),
        .idx_o (arb_idx_s),
        .vld_o (arb_vld_s)
    );

    // Pick the winning channel's descriptor address.
    always_comb begin
        addr_sel_s = 64'd0;
        for (int i = 0; i < NCH; i++) begin
            if (arb_idx_s == PW'(i)) begin
                addr_sel_s = CH_ADDR[64*i +: 64];
            end else begin
                addr_sel_s = addr_sel_s;
            end
        end
    end

    // Lowest clear bit of the registered busy map is the next tag to hand out.
    always_comb begin
        free_vld_s = 1'b0;
        free_idx_s = '0;
        for (int i = MAX_OUTS - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                free_vld_s = 1'b1;
                free_idx_s = TIW'(i);
            end else begin
                free_vld_s = free_vld_s;
            end
        end
    end

    // Decode a completion EOP: a hit is an in-range tag whose bit is set.
    always_comb begin
        cp_eop_s = DFK_CP_DVLD & DFK_CP_EOP;
        cp_off_s = {1'b0, DFK_CP_TAG} - {1'b0, TAG_BASE};
        cp_idx_s = cp_off_s[TIW-1:0];
        if (cp_off_s < 9'(MAX_OUTS)) begin
            cp_hit_s = cp_eop_s & busy_q[cp_idx_s];
        end else begin
            cp_hit_s = 1'b0;
        end
    end

    // Issue FSM: latch winner, address and tag in IDLE; hold the read in ISSUE until RDY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_idx_d = win_idx_q;
        win_oh_d  = win_oh_q;
        addr_d    = addr_q;
        tag_d     = tag_q;
        accept_s  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ENABLE && arb_vld_s && free_vld_s) begin
                    state_d   = ST_ISSUE;
                    win_idx_d = arb_idx_s;
                    win_oh_d  = arb_gnt_s;
                    addr_d    = addr_sel_s;
                    tag_d     = free_idx_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (DFK_RQ_RDY && PCIE_RST_N) begin
                    accept_s = 1'b1;
                    state_d  = ST_IDLE;
                    if (win_idx_q == PW'(NCH - 1)) begin
                        ptr_d = '0;
                    end else begin
                        ptr_d = win_idx_q + PW'(1);
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Busy map, watchdog and error pulses; a free and an allocation may land together.
    always_comb begin
        free_mask_s  = cp_hit_s ? (MAX_OUTS'(1) << cp_idx_s) : '0;
        alloc_mask_s = accept_s ? (MAX_OUTS'(1) << tag_q) : '0;
        unexp_d      = cp_eop_s & ~cp_hit_s;
        tmo_d        = 1'b0;
        busy_d       = (busy_q & ~free_mask_s) | alloc_mask_s;
        if ((busy_q == '0) || cp_hit_s) begin
            wdog_d = 32'd0;
        end else if (wdog_q == 32'(TMO_CYC - 1)) begin
            wdog_d = 32'd0;
            tmo_d  = 1'b1;
            busy_d = alloc_mask_s;
        end else begin
            wdog_d = wdog_q + 32'd1;
        end
    end

    // Outstanding count is the popcount of the registered map (one cycle behind it).
    always_comb begin
        busy_ext_s                 = '0;
        busy_ext_s[MAX_OUTS-1:0]   = busy_q;
        cnt_d                      = popcount16(busy_ext_s);
    end

    // All state registers, cleared by the synchronous active-low reset.
    always_ff @(posedge PCIE_CLK) begin
        if (!PCIE_RST_N) begin
            state_q   <= ST_IDLE;
            busy_q    <= '0;
            ptr_q     <= '0;
            win_idx_q <= '0;
            win_oh_q  <= '0;
            addr_q    <= 64'd0;
            tag_q     <= '0;
            wdog_q    <= 32'd0;
            cnt_q     <= 5'd0;
            unexp_q   <= 1'b0;
            tmo_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            busy_q    <= busy_d;
            ptr_q     <= ptr_d;
            win_idx_q <= win_idx_d;
            win_oh_q  <= win_oh_d;
            addr_q    <= addr_d;
            tag_q     <= tag_d;
            wdog_q    <= wdog_d;
            cnt_q     <= cnt_d;
            unexp_q   <= unexp_d;
            tmo_q     <= tmo_d;
        end
    end

    assign DFK_RQ_VLD  = (state_q == ST_ISSUE);
    assign DFK_RQ_ADDR = DFK_RQ_VLD ? addr_q : 64'd0;
    assign DFK_RQ_TAG  = DFK_RQ_VLD ? (TAG_BASE + TAG_W'(tag_q)) : 8'h00;
    assign DFK_RQ_DCNT = DFK_RQ_VLD ? DESC_DCNT : 12'd0;
    assign CH_GNT      = accept_s ? win_oh_q : '0;
    assign OUTS_CNT    = cnt_q;
    assign BUSY        = (cnt_q != 5'd0) || (state_q == ST_ISSUE);
    assign UNEXP_TAG   = unexp_q;
    assign TMO_ERR     = tmo_q;

endmodule

// File: tb/tb_pcie_dn_dfk_sched.sv
// Self-checking bench for pcie_dn_dfk_sched: directed scenarios followed by
// random traffic, every cycle compared against a transaction-level model.
module tb_pcie_dn_dfk_sched;

    localparam int         NCH   = 4;
    localparam int         MAXO  = 4;
    localparam int         TMO   = 100;
    localparam logic [7:0] TBASE = 8'h00;

    logic              clk = 1'b0;
    logic              rst_n, en, rdy, cp_eop, cp_dvld;
    logic [NCH-1:0]    req;
    logic [NCH*64-1:0] addr;
    logic [7:0]        cp_tag;
    logic [NCH-1:0]    gnt;
    logic              vld, busy, unexp, tmo;
    logic [63:0]       rq_addr;
    logic [7:0]        rq_tag;
    logic [11:0]       rq_dcnt;
    logic [4:0]        outs_cnt;

    always #5 clk = ~clk;

    pcie_dn_dfk_sched #(
        .NCH(NCH), .MAX_OUTS(MAXO), .TAG_BASE(TBASE), .DESC_DCNT(12'd8), .TMO_CYC(TMO)
    ) dut (
        .PCIE_CLK(clk), .PCIE_RST_N(rst_n), .ENABLE(en), .CH_REQ(req), .CH_ADDR(addr),
        .CH_GNT(gnt), .DFK_RQ_VLD(vld), .DFK_RQ_RDY(rdy), .DFK_RQ_ADDR(rq_addr),
        .DFK_RQ_TAG(rq_tag), .DFK_RQ_DCNT(rq_dcnt), .DFK_CP_EOP(cp_eop),
        .DFK_CP_DVLD(cp_dvld), .DFK_CP_TAG(cp_tag), .OUTS_CNT(outs_cnt), .BUSY(busy),
        .UNEXP_TAG(unexp), .TMO_ERR(tmo)
    );

    // Reference model: pending read, set of outstanding tags, next-priority channel.
    bit          m_pend;
    int          m_ch, m_tag, m_next, m_wd, m_cnt;
    logic [63:0] m_addr;
    bit          m_outs [MAXO];
    bit          m_unexp, m_tmo;
    int          acc_ch, acc_tag;
    int          n_cmp = 0;
    int          n_err = 0;
    bit          chk_en = 1'b0;
    int          gnt_log [$];

    task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
        end
    endtask

    function automatic int outs_count();
        int s = 0;
        foreach (m_outs[i]) s += int'(m_outs[i]);
        return s;
    endfunction

    // One clock: compare every output with the model, advance the model, cross the edge.
    task automatic cycle();
        logic [NCH-1:0] e_gnt;
        bit is_eop, hit, flush, found;
        int off, cnt_now, pick, ft;
        #2;
        e_gnt = '0;
        if (m_pend && rdy && rst_n) e_gnt[m_ch] = 1'b1;
        if (chk_en) begin
            chk("CH_GNT", 64'(gnt), 64'(e_gnt));
            chk("RQ_VLD", 64'(vld), 64'(m_pend));
            chk("RQ_ADDR", rq_addr, m_pend ? m_addr : 64'd0);
            chk("RQ_TAG", 64'(rq_tag), m_pend ? 64'(m_tag + int'(TBASE)) : 64'd0);
            chk("RQ_DCNT", 64'(rq_dcnt), m_pend ? 64'd8 : 64'd0);
            chk("OUTS_CNT", 64'(outs_cnt), 64'(m_cnt));
            chk("BUSY", 64'(busy), 64'((m_cnt != 0) || m_pend));
            chk("UNEXP_TAG", 64'(unexp), 64'(m_unexp));
            chk("TMO_ERR", 64'(tmo), 64'(m_tmo));
        end
        acc_ch = -1;
        acc_tag = -1;
        if (!rst_n) begin
            m_pend = 0; m_ch = 0; m_tag = 0; m_next = 0; m_wd = 0; m_cnt = 0;
            m_addr = 64'd0; m_unexp = 0; m_tmo = 0;
            foreach (m_outs[i]) m_outs[i] = 0;
        end else begin
            cnt_now = outs_count();
            is_eop = cp_dvld && cp_eop;
            off = int'(cp_tag) - int'(TBASE);
            hit = 0;
            if (is_eop && off >= 0 && off < MAXO) hit = m_outs[off];
            m_unexp = is_eop && !hit;
            m_tmo = 0;
            flush = 0;
            if (cnt_now == 0 || hit) m_wd = 0;
            else if (m_wd == TMO - 1) begin m_wd = 0; m_tmo = 1; flush = 1; end
            else m_wd++;
            m_cnt = cnt_now;
            if (m_pend) begin
                if (rdy) begin
                    acc_ch = m_ch; acc_tag = m_tag;
                    m_next = (m_ch + 1) % NCH;
                    m_pend = 0;
                end
            end else if (en && req != '0 && cnt_now < MAXO) begin
                found = 0; pick = 0;
                for (int k = 0; k < NCH; k++) begin
                    int c = (m_next + k) % NCH;
                    if (!found && req[c]) begin found = 1; pick = c; end
                end
                ft = 0;
                for (int t = MAXO - 1; t >= 0; t--) if (!m_outs[t]) ft = t;
                m_ch = pick; m_tag = ft; m_addr = addr[64*pick +: 64]; m_pend = 1;
            end
            if (hit) m_outs[off] = 0;
            if (flush) foreach (m_outs[i]) m_outs[i] = 0;
            if (acc_tag >= 0) m_outs[acc_tag] = 1;
        end
        @(posedge clk);
        #1;
        req = req & ~e_gnt;
    endtask

    task automatic cpl(input logic [7:0] tg);
        cp_dvld = 1'b1; cp_eop = 1'b1; cp_tag = tg;
        cycle();
        cp_dvld = 1'b0; cp_eop = 1'b0;
    endtask

    task automatic wait_vld(input string nm, input int lim);
        int n = 0;
        while (!m_pend && n < lim) begin cycle(); n++; end
        chk(nm, 64'(vld), 64'd1);
    endtask

    task automatic reset_dut();
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n;
        logic [63:0] a0;
        logic [7:0] tg;
        int lst [$];
        rst_n = 1'b0; en = 1'b1; req = '0; addr = '0; rdy = 1'b0;
        cp_eop = 1'b0; cp_dvld = 1'b0; cp_tag = 8'h00;
        @(posedge clk); #1;
        cycle();
        chk_en = 1'b1;
        cycle();
        chk("rst_vld", 64'(vld), 64'd0);
        chk("rst_cnt", 64'(outs_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Single request on channel 2.
        rdy = 1'b1; addr[2*64 +: 64] = 64'h1000; req = 4'b0100;
        cycle();
        chk("t1_vld", 64'(vld), 64'd1);
        chk("t1_addr", rq_addr, 64'h1000);
        chk("t1_tag", 64'(rq_tag), 64'd0);
        chk("t1_dcnt", 64'(rq_dcnt), 64'd8);
        chk("t1_gnt", 64'(gnt), 64'b0100);
        cycle(); cycle(); cycle();
        chk("t1_cnt1", 64'(outs_cnt), 64'd1);
        cpl(8'h00); cycle();
        chk("t1_cnt0", 64'(outs_cnt), 64'd0);

        // Fairness with all channels requesting and immediate completions.
        reset_dut();
        gnt_log.delete();
        for (int i = 0; i < 40 && gnt_log.size() < 5; i++) begin
            req = 4'hF;
            cycle();
            cp_dvld = 1'b0; cp_eop = 1'b0;
            if (acc_ch >= 0) begin
                gnt_log.push_back(acc_ch);
                cp_dvld = 1'b1; cp_eop = 1'b1; cp_tag = 8'(acc_tag) + TBASE;
            end
        end
        req = '0;
        cycle();
        cp_dvld = 1'b0; cp_eop = 1'b0;
        cycle(); cycle();
        chk("t2_ngrants", 64'(gnt_log.size()), 64'd5);
        for (int k = 0; k < gnt_log.size(); k++) chk("t2_order", 64'(gnt_log[k]), 64'(k % NCH));

        // Backpressure, credit exhaustion and tag reuse.
        reset_dut();
        rdy = 1'b0; a0 = {$urandom, $urandom}; addr[0 +: 64] = a0; req = 4'b0001;
        cycle();
        for (int i = 0; i < 10; i++) begin
            chk("t3_vld_hold", 64'(vld), 64'd1);
            chk("t3_addr_hold", rq_addr, a0);
            cycle();
        end
        rdy = 1'b1; cycle();
        for (int c = 1; c < NCH; c++) addr[64*c +: 64] = {$urandom, $urandom};
        req = 4'b1110;
        for (int i = 0; i < 20 && outs_count() < 4; i++) cycle();
        cycle();
        chk("t3_cnt4", 64'(outs_cnt), 64'd4);
        req = 4'b0001;
        for (int i = 0; i < 6; i++) begin cycle(); chk("t3_no_vld", 64'(vld), 64'd0); end
        cpl(8'h02);
        wait_vld("t3_revld", 5);
        chk("t3_tag2", 64'(rq_tag), 64'd2);
        cycle();
        req = '0;
        for (int t = 0; t < MAXO; t++) cpl(8'(t) + TBASE);
        cycle();

        // Same-cycle free of tag 1 and allocation of tag 3.
        reset_dut();
        rdy = 1'b1; req = 4'b0111;
        for (int i = 0; i < 20 && !(outs_count() == 3 && !m_pend && req == '0); i++) cycle();
        rdy = 1'b0; req = 4'b1000;
        wait_vld("t4_vld", 5);
        chk("t4_tag3", 64'(rq_tag), 64'd3);
        cycle(); cycle();
        chk("t4_cnt_before", 64'(outs_cnt), 64'd3);
        rdy = 1'b1;
        cpl(8'h01);
        rdy = 1'b0;
        cycle();
        chk("t4_cnt_after", 64'(outs_cnt), 64'd3);
        cpl(8'h01);
        chk("t4_tag1_gone", 64'(unexp), 64'd1);

        // Unexpected tag and completion watchdog.
        cpl(8'h20);
        chk("t5_unexp", 64'(unexp), 64'd1);
        cycle();
        chk("t5_unexp_pulse", 64'(unexp), 64'd0);
        reset_dut();
        rdy = 1'b1; req = 4'b0001;
        cycle(); cycle();
        n = 0;
        while (tmo !== 1'b1 && n < 200) begin cycle(); n++; end
        chk("t5_tmo_cycle", 64'(n), 64'd100);
        cycle();
        chk("t5_tmo_pulse", 64'(tmo), 64'd0);
        chk("t5_tmo_cnt", 64'(outs_cnt), 64'd0);
        cpl(8'h00);
        chk("t5_late_unexp", 64'(unexp), 64'd1);

        // ENABLE low blocks new reads.
        en = 1'b0; req = 4'hF;
        for (int i = 0; i < 4; i++) begin cycle(); chk("t6_en_low", 64'(vld), 64'd0); end
        en = 1'b1; req = '0;

        // Reset while a read is presented.
        reset_dut();
        rdy = 1'b1; req = 4'b0001; cycle(); cycle();
        rdy = 1'b0; req = 4'b0010; cycle();
        chk("t7_vld", 64'(vld), 64'd1);
        rst_n = 1'b0; cycle(); rst_n = 1'b1;
        chk("t7_vld0", 64'(vld), 64'd0);
        chk("t7_cnt0", 64'(outs_cnt), 64'd0);
        chk("t7_gnt0", 64'(gnt), 64'd0);
        req = '0;

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            int r;
            rst_n = ($urandom_range(0, 499) != 0);
            en = ($urandom_range(0, 9) != 0);
            req = req | (4'($urandom) & 4'($urandom));
            for (int c = 0; c < NCH; c++) addr[64*c +: 64] = {$urandom, $urandom};
            rdy = ($urandom_range(0, 3) != 0);
            cp_dvld = 1'b0; cp_eop = 1'b0; cp_tag = 8'($urandom);
            lst.delete();
            foreach (m_outs[t]) if (m_outs[t]) lst.push_back(t);
            r = $urandom_range(0, 9);
            if (r < 4 && lst.size() > 0) begin
                tg = 8'(lst[$urandom_range(0, lst.size() - 1)]) + TBASE;
                cp_dvld = 1'b1; cp_eop = ($urandom_range(0, 3) != 0); cp_tag = tg;
            end else if (r == 4) begin
                cp_dvld = 1'b1; cp_eop = 1'b1;
            end else if (r == 5) begin
                cp_eop = 1'b1;
            end
            cycle();
        end
        rst_n = 1'b1; cp_dvld = 1'b0; cp_eop = 1'b0; req = '0;
        cycle(); cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
